// File: rtl/clk_en_gen_pkg.sv
// Shared types and constants for the fractional clock-enable generator.
// Holds the FSM encoding, the config request payload and the config validity check.
package clk_en_gen_pkg;

  typedef enum logic [0:0] {
    ST_SETTLE = 1'b0,
    ST_RUN    = 1'b1
  } state_e;

  // Default build: 50 MHz refclk -> 10 / 16 / 4 MHz strobes on channels 0 / 1 / 2
  localparam int unsigned DEF_NUM_CH      = 3;
  localparam int unsigned DEF_ACC_W       = 16;
  localparam int unsigned DEF_LOCK_CYCLES = 16;
  localparam logic [DEF_NUM_CH*DEF_ACC_W-1:0] DEF_NUM_50M = {16'd2, 16'd8, 16'd1};
  localparam logic [DEF_NUM_CH*DEF_ACC_W-1:0] DEF_DEN_50M = {16'd25, 16'd25, 16'd5};

  // Config fields are zero-extended to this width before validation
  localparam int unsigned CFG_CMP_W = 32;

  typedef struct packed {
    logic [CFG_CMP_W-1:0] ch;
    logic [CFG_CMP_W-1:0] num;
    logic [CFG_CMP_W-1:0] den;
  } cfg_req_t;

  // A ratio is usable only when it names a real channel and 0 < num <= den
  function automatic logic cfg_valid(input cfg_req_t req, input logic [CFG_CMP_W-1:0] num_ch);
    return (req.ch < num_ch) && (req.num != '0) && (req.den != '0) && (req.num <= req.den);
  endfunction

endpackage

// File: rtl/clk_en_gen_if.sv
// Ratio configuration port of clk_en_gen: write strobe, target channel,
// new numerator/denominator and the one-cycle rejection pulse.
interface clk_en_gen_if
  import clk_en_gen_pkg::*;
#(
  parameter int unsigned NUM_CH = DEF_NUM_CH,
  parameter int unsigned ACC_W  = DEF_ACC_W
);

  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic             cfg_we;
  logic [CH_W-1:0]  cfg_ch;
  logic [ACC_W-1:0] cfg_num;
  logic [ACC_W-1:0] cfg_den;
  logic             cfg_err;

  modport master (
    output cfg_we,
    output cfg_ch,
    output cfg_num,
    output cfg_den,
    input  cfg_err
  );

  modport slave (
    input  cfg_we,
    input  cfg_ch,
    input  cfg_num,
    input  cfg_den,
    output cfg_err
  );

endinterface

// File: rtl/clk_en_chan.sv
// One fractional clock-enable channel: holds its own num/den ratio and a
// modulo-den phase accumulator; emits a registered one-cycle strobe per wrap.
module clk_en_chan
  import clk_en_gen_pkg::*;
#(
  parameter int unsigned      ACC_W   = DEF_ACC_W,
  parameter logic [ACC_W-1:0] DEF_NUM = ACC_W'(1),
  parameter logic [ACC_W-1:0] DEF_DEN = ACC_W'(5)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             clear,
  input  logic             load,
  input  logic [ACC_W-1:0] num,
  input  logic [ACC_W-1:0] den,
  output logic             ce
);

  logic [ACC_W-1:0] num_q;
  logic [ACC_W-1:0] den_q;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic             ce_d;
  logic [ACC_W:0]   sum_c;
  logic [ACC_W:0]   diff_c;
  logic             hit_c;

  // Extra sum bit keeps acc + num from wrapping before the compare
  always_comb begin
    sum_c  = {1'b0, acc_q} + {1'b0, num_q};
    diff_c = sum_c - {1'b0, den_q};
    hit_c  = (sum_c >= {1'b0, den_q});
  end

  always_comb begin
    acc_d = acc_q;
    ce_d  = 1'b0;
    if (clear) begin
      acc_d = '0;
    end else if (run) begin
      acc_d = hit_c ? ACC_W'(diff_c) : ACC_W'(sum_c);
      ce_d  = hit_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      num_q <= DEF_NUM;
      den_q <= DEF_DEN;
      acc_q <= '0;
      ce    <= 1'b0;
    end else begin
      if (load) begin
        num_q <= num;
        den_q <= den;
      end
      acc_q <= acc_d;
      ce    <= ce_d;
    end
  end

endmodule

// File: rtl/clk_en_gen.sv
// Multi-channel fractional clock-enable generator on a single refclk domain.
// Settles for LOCK_CYCLES after reset or any accepted ratio change before releasing strobes.
module clk_en_gen
  import clk_en_gen_pkg::*;
#(
  parameter int unsigned              NUM_CH      = DEF_NUM_CH,
  parameter int unsigned              ACC_W       = DEF_ACC_W,
  parameter logic [NUM_CH*ACC_W-1:0]  DEF_NUM     = DEF_NUM_50M,
  parameter logic [NUM_CH*ACC_W-1:0]  DEF_DEN     = DEF_DEN_50M,
  parameter int unsigned              LOCK_CYCLES = DEF_LOCK_CYCLES
) (
  input  logic              refclk,
  input  logic              rst,
  clk_en_gen_if.slave       cfg,
  input  logic              sync,
  output logic [NUM_CH-1:0] ce,
  output logic              locked
);

  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             locked_d;
  logic             cfg_err_q;
  logic             cfg_err_d;

  cfg_req_t         req_c;
  logic             cfg_ok_c;
  logic             run_c;
  logic             clear_c;

  // Config write validation on zero-extended fields
  always_comb begin
    req_c     = '0;
    req_c.ch  = CFG_CMP_W'(cfg.cfg_ch);
    req_c.num = CFG_CMP_W'(cfg.cfg_num);
    req_c.den = CFG_CMP_W'(cfg.cfg_den);
    cfg_ok_c  = cfg.cfg_we & cfg_valid(req_c, CFG_CMP_W'(NUM_CH));
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q   <= ST_SETTLE;
      cnt_q     <= '0;
      locked    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      locked    <= locked_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  // An accepted write always restarts settling, from either state
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    locked_d  = 1'b0;
    cfg_err_d = 1'b0;
    case (state_q)
      ST_SETTLE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_SETTLE;
    endcase
    if (cfg_ok_c) begin
      state_d = ST_SETTLE;
      cnt_d   = '0;
    end
    locked_d  = (state_d == ST_RUN);
    cfg_err_d = cfg.cfg_we & ~cfg_ok_c;
  end

  assign cfg.cfg_err = cfg_err_q;

  // Accumulators only move in RUN; settling, relock and sync all zero them
  assign run_c   = (state_q == ST_RUN);
  assign clear_c = ~run_c | cfg_ok_c | sync;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    clk_en_chan #(
      .ACC_W   (ACC_W),
      .DEF_NUM (DEF_NUM[i*ACC_W +: ACC_W]),
      .DEF_DEN (DEF_DEN[i*ACC_W +: ACC_W])
    ) u_chan (
      .clk   (refclk),
      .rst   (rst),
      .run   (run_c),
      .clear (clear_c),
      .load  (cfg_ok_c && (cfg.cfg_ch == CH_W'(i))),
      .num   (cfg.cfg_num),
      .den   (cfg.cfg_den),
      .ce    (ce[i])
    );
  end

endmodule

// File: tb/tb_clk_en_gen.sv
// Directed bench for clk_en_gen: lock timing, default ratios, reconfiguration,
// rejected writes, phase alignment, collisions and mid-settle reset.
module tb_clk_en_gen;

  logic       refclk;
  logic       rst;
  logic       sync;
  logic [2:0] ce;
  logic       locked;

  int n_vec = 0;
  int n_err = 0;

  // Ratios the bench expects each channel to be running
  int en[3];
  int ed[3];

  clk_en_gen_if #(.NUM_CH(3), .ACC_W(16)) cfg_bus ();

  clk_en_gen u_dut (
    .refclk (refclk),
    .rst    (rst),
    .cfg    (cfg_bus.slave),
    .sync   (sync),
    .ce     (ce),
    .locked (locked)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // One rising edge, then settle on the falling edge for sampling and driving
  task automatic step();
    @(posedge refclk);
    @(negedge refclk);
  endtask

  // Strobe expected m cycles after a phase reference: floor(m*n/d) steps up
  function automatic logic [2:0] exp_ce(input int m);
    logic [2:0] r;
    for (int i = 0; i < 3; i++)
      r[i] = ((m * en[i]) / ed[i]) != (((m - 1) * en[i]) / ed[i]);
    return r;
  endfunction

  task automatic cfg_drive(input logic we, input logic [1:0] ch, input logic [15:0] nm, input logic [15:0] dn);
    cfg_bus.cfg_we  = we;
    cfg_bus.cfg_ch  = ch;
    cfg_bus.cfg_num = nm;
    cfg_bus.cfg_den = dn;
  endtask

  task automatic wait_lock();
    for (int k = 1; k <= 15; k++) begin
      step();
      chk("settle_locked", 32'(locked), 32'd0);
      chk("settle_ce", 32'(ce), 32'd0);
    end
    step();
    chk("lock_rise", 32'(locked), 32'd1);
  endtask

  task automatic set_defaults();
    en[0] = 1; ed[0] = 5;
    en[1] = 8; ed[1] = 25;
    en[2] = 2; ed[2] = 25;
  endtask

  int n;
  int c0, c2, w1;
  logic [15:0] bad_num [3];
  logic [15:0] bad_den [3];
  logic [1:0]  bad_ch  [3];

  initial begin
    rst  = 1'b1;
    sync = 1'b0;
    cfg_drive(1'b0, 2'd0, 16'd0, 16'd0);
    set_defaults();
    bad_num[0] = 16'd3; bad_den[0] = 16'd2; bad_ch[0] = 2'd0;
    bad_num[1] = 16'd1; bad_den[1] = 16'd0; bad_ch[1] = 2'd1;
    bad_num[2] = 16'd1; bad_den[2] = 16'd2; bad_ch[2] = 2'd3;

    @(negedge refclk);
    for (int k = 0; k < 3; k++) step();
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_ce", 32'(ce), 32'd0);
    chk("rst_cfg_err", 32'(cfg_bus.cfg_err), 32'd0);
    rst = 1'b0;

    // Lock after exactly 16 edges with rst low
    wait_lock();

    // Default ratios over 1000 RUN cycles
    c0 = 0; c2 = 0; w1 = 0;
    for (n = 1; n <= 1000; n++) begin
      step();
      if (ce[0]) c0++;
      if (ce[1]) w1++;
      if (ce[2]) c2++;
      if (n <= 25) chk("run_ce", 32'(ce), 32'(exp_ce(n)));
      if (n % 25 == 0) begin
        chk("ch1_window", 32'(w1), 32'd8);
        w1 = 0;
      end
    end
    chk("ch0_total", 32'(c0), 32'd200);
    chk("ch2_total", 32'(c2), 32'd80);
    n = 1000;

    // Rejected writes: one cfg_err pulse each, no disturbance to strobes
    for (int i = 0; i < 3; i++) begin
      cfg_drive(1'b1, bad_ch[i], bad_num[i], bad_den[i]);
      step(); n++;
      cfg_drive(1'b0, 2'd0, 16'd0, 16'd0);
      chk("bad_cfg_err", 32'(cfg_bus.cfg_err), 32'd1);
      chk("bad_locked", 32'(locked), 32'd1);
      chk("bad_ce", 32'(ce), 32'(exp_ce(n)));
      step(); n++;
      chk("bad_err_drop", 32'(cfg_bus.cfg_err), 32'd0);
      chk("bad_ce2", 32'(ce), 32'(exp_ce(n)));
    end
    for (int k = 0; k < 3; k++) begin
      step(); n++;
      chk("pre_sync_ce", 32'(ce), 32'(exp_ce(n)));
    end

    // sync together with a rejected write: sync applies and cfg_err pulses
    sync = 1'b1;
    cfg_drive(1'b1, 2'd3, 16'd1, 16'd2);
    step();
    sync = 1'b0;
    cfg_drive(1'b0, 2'd0, 16'd0, 16'd0);
    chk("sync_ce", 32'(ce), 32'd0);
    chk("sync_cfg_err", 32'(cfg_bus.cfg_err), 32'd1);
    chk("sync_locked", 32'(locked), 32'd1);
    for (int m = 1; m <= 13; m++) begin
      step();
      chk("align_ce", 32'(ce), 32'(exp_ce(m)));
    end

    // Valid write with sync: relock only, ch0 becomes 1/2
    sync = 1'b1;
    cfg_drive(1'b1, 2'd0, 16'd1, 16'd2);
    step();
    sync = 1'b0;
    cfg_drive(1'b0, 2'd0, 16'd0, 16'd0);
    chk("relock_locked", 32'(locked), 32'd0);
    chk("relock_ce", 32'(ce), 32'd0);
    chk("relock_cfg_err", 32'(cfg_bus.cfg_err), 32'd0);
    wait_lock();
    en[0] = 1; ed[0] = 2;
    for (int m = 1; m <= 26; m++) begin
      step();
      chk("half_ce", 32'(ce), 32'(exp_ce(m)));
    end

    // Reset during SETTLE with a rejected write in the same cycle
    cfg_drive(1'b1, 2'd2, 16'd1, 16'd1);
    step();
    cfg_drive(1'b0, 2'd0, 16'd0, 16'd0);
    chk("pre_rst_locked", 32'(locked), 32'd0);
    for (int k = 0; k < 4; k++) step();
    rst = 1'b1;
    cfg_drive(1'b1, 2'd1, 16'd0, 16'd3);
    step();
    rst = 1'b0;
    cfg_drive(1'b0, 2'd0, 16'd0, 16'd0);
    chk("mid_rst_locked", 32'(locked), 32'd0);
    chk("mid_rst_ce", 32'(ce), 32'd0);
    chk("mid_rst_cfg_err", 32'(cfg_bus.cfg_err), 32'd0);
    wait_lock();
    set_defaults();
    for (int m = 1; m <= 25; m++) begin
      step();
      chk("restored_ce", 32'(ce), 32'(exp_ce(m)));
    end

    // num == den on ch2: strobe every RUN cycle
    cfg_drive(1'b1, 2'd2, 16'd5, 16'd5);
    step();
    cfg_drive(1'b0, 2'd0, 16'd0, 16'd0);
    chk("eq_cfg_err", 32'(cfg_bus.cfg_err), 32'd0);
    chk("eq_locked", 32'(locked), 32'd0);
    wait_lock();
    en[2] = 5; ed[2] = 5;
    for (int m = 1; m <= 10; m++) begin
      step();
      chk("eq_ce", 32'(ce), 32'(exp_ce(m)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
